serial_bcd_alu_n: RTL and testbench

//  Next-generation bit-serial BCD ALU: parametrised digit count, frame FSM, digit-serial compute.

---
 rtl/serial_bcd_alu_n.sv | 155 +++++++++++++++
 tb/tb_serial_bcd_alu_n.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/serial_bcd_alu_n.sv
// Bit-serial BCD add/subtract/compare engine: hunts for a header, receives op + two
// DIGITS-digit operands, computes one digit per cycle and returns a framed response.
module serial_bcd_alu_n #(
    parameter int          DIGITS = 4,
    parameter logic [7:0]  HDR    = 8'hA5,
    parameter logic [7:0]  RSP    = 8'h96
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic result,
    output logic busy,
    output logic frame_done
);

    // state  | meaning
    // HUNT   | shift din into header window, wait for HDR
    // RECV   | shift in op, A, B (P bits)
    // CHECK  | validate op and digits, latch operands
    // CALC   | one BCD digit per cycle, up to two passes for subtract
    // SEND   | shift out RSP, status, result digits

    localparam int W  = 4 * DIGITS;
    localparam int P  = 2 + 2 * W;
    localparam int L  = 16 + W;
    localparam int CW = $clog2(P + L);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_CMP = 2'b10;

    typedef enum logic [2:0] {S_HUNT, S_RECV, S_CHECK, S_CALC, S_SEND} state_t;

    state_t         r_state, w_state_next;
    logic [7:0]     r_win;
    logic [P-1:0]   r_frame;
    logic [CW-1:0]  r_cnt;
    logic [1:0]     r_op;
    logic [W-1:0]   r_a, r_b, r_sum;
    logic           r_carry, r_pass, r_eq;
    logic [L-1:0]   r_rsp;

    logic [7:0]     w_win_next;
    logic           w_match, w_bad, w_err, w_last, w_calc_end;
    logic [1:0]     w_op;
    logic [W-1:0]   w_fa, w_fb, w_sum_next;
    logic [3:0]     w_x, w_yb, w_y;
    logic [4:0]     w_s0, w_s;

    assign w_win_next = {r_win[6:0], din};
    assign w_match    = (w_win_next == HDR);

    assign w_op = r_frame[P-1 -: 2];
    assign w_fa = r_frame[2*W-1 -: W];
    assign w_fb = r_frame[W-1:0];

    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_fa[4*i +: 4] > 4'd9 || w_fb[4*i +: 4] > 4'd9) w_bad = 1'b1;
        end
    end
    assign w_err = (w_op == 2'b11) | w_bad;

    // Pass 2 of a negative subtract swaps the operands: B + (9's complement of A) + 1.
    assign w_x  = r_pass ? r_b[3:0] : r_a[3:0];
    assign w_yb = r_pass ? r_a[3:0] : r_b[3:0];
    assign w_y  = (r_op == OP_ADD) ? w_yb : 4'd9 - w_yb;
    assign w_s0 = {1'b0, w_x} + {1'b0, w_y} + {4'd0, r_carry};
    assign w_s  = (w_s0 > 5'd9) ? w_s0 + 5'd6 : w_s0;

    assign w_last     = (r_cnt == CW'(DIGITS - 1));
    assign w_sum_next = (r_sum >> 4) | (W'(w_s[3:0]) << (W - 4));
    assign w_calc_end = w_last & ((r_op == OP_ADD) | r_pass | w_s[4]);

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_HUNT;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_HUNT:  if (w_match)                  w_state_next = S_RECV;
            S_RECV:  if (r_cnt == CW'(P - 1))      w_state_next = S_CHECK;
            S_CHECK: w_state_next = w_err ? S_SEND : S_CALC;
            S_CALC:  if (w_calc_end)               w_state_next = S_SEND;
            S_SEND:  if (r_cnt == CW'(L - 1))      w_state_next = S_HUNT;
            default: w_state_next = S_HUNT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_win   <= '0;
            r_frame <= '0;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_pass  <= 1'b0;
            r_eq    <= 1'b0;
            r_rsp   <= '0;
        end else begin
            case (r_state)
                S_HUNT: begin
                    r_win <= w_match ? 8'h00 : w_win_next;
                    r_cnt <= '0;
                end
                S_RECV: begin
                    r_frame <= {r_frame[P-2:0], din};
                    r_cnt   <= (r_cnt == CW'(P - 1)) ? '0 : r_cnt + 1'b1;
                end
                S_CHECK: begin
                    r_op    <= w_op;
                    r_a     <= w_fa;
                    r_b     <= w_fb;
                    r_sum   <= '0;
                    r_carry <= (w_op != OP_ADD);
                    r_pass  <= 1'b0;
                    r_eq    <= (w_op == OP_CMP) && (w_fa == w_fb);
                    r_cnt   <= '0;
                    if (w_err) r_rsp <= {RSP, 8'h08, {W{1'b0}}};
                end
                S_CALC: begin
                    // Operands rotate so they are back in place for a second pass.
                    r_a     <= (r_a >> 4) | (r_a << (W - 4));
                    r_b     <= (r_b >> 4) | (r_b << (W - 4));
                    r_sum   <= w_sum_next;
                    r_carry <= w_s[4];
                    r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
                    if (w_calc_end) begin
                        r_rsp <= {RSP, 4'b0000, 1'b0, r_eq, r_pass,
                                  (r_op == OP_ADD) & w_s[4],
                                  (r_op == OP_CMP) ? {W{1'b0}} : w_sum_next};
                    end else if (w_last) begin
                        r_pass  <= 1'b1;
                        r_carry <= 1'b1;
                    end
                end
                S_SEND: begin
                    r_rsp <= r_rsp << 1;
                    r_cnt <= (r_cnt == CW'(L - 1)) ? '0 : r_cnt + 1'b1;
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign result     = (r_state == S_SEND) & r_rsp[L-1];
    assign busy       = (r_state != S_HUNT);
    assign frame_done = (r_state == S_SEND) && (r_cnt == CW'(L - 1));

endmodule

// File: tb/tb_serial_bcd_alu_n.sv
// Directed and golden-model checks of serial_bcd_alu_n at DIGITS = 4, 2 and 6.
module tb_serial_bcd_alu_n;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic din   = 1'b0;
    int   sel   = 0;
    int   checks = 0;
    int   errors = 0;

    logic [2:0] w_din, w_res, w_busy, w_done;

    always #5 clock = ~clock;

    assign w_din[0] = (sel == 0) ? din : 1'b0;
    assign w_din[1] = (sel == 1) ? din : 1'b0;
    assign w_din[2] = (sel == 2) ? din : 1'b0;

    serial_bcd_alu_n #(.DIGITS(4)) u_d4 (.clock(clock), .reset(reset), .din(w_din[0]),
        .result(w_res[0]), .busy(w_busy[0]), .frame_done(w_done[0]));
    serial_bcd_alu_n #(.DIGITS(2)) u_d2 (.clock(clock), .reset(reset), .din(w_din[1]),
        .result(w_res[1]), .busy(w_busy[1]), .frame_done(w_done[1]));
    serial_bcd_alu_n #(.DIGITS(6)) u_d6 (.clock(clock), .reset(reset), .din(w_din[2]),
        .result(w_res[2]), .busy(w_busy[2]), .frame_done(w_done[2]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_bits(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            din = v[i];
            tick();
        end
    endtask

    function automatic int bcd2int(input logic [23:0] v, input int d);
        int r = 0;
        for (int i = d - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [23:0] int2bcd(input int v, input int d);
        logic [23:0] r = '0;
        int t = v;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Drives one request and checks latency, framing and payload of the response.
    // Latency is counted from the header-match edge to the edge that samples response bit 0.
    task automatic run_frame(input string tag, input int s, input int d, input logic [1:0] op,
                             input logic [23:0] a, input logic [23:0] b,
                             input logic [7:0] exp_st, input logic [23:0] exp_dig,
                             input int calc, input logic [15:0] pre, input int npre);
        int p = 2 + 8 * d;
        int l = 16 + 4 * d;
        int k;
        int ndone = 0;
        logic busy_ok = 1'b1;
        logic [63:0] rsp = '0;
        sel = s;
        send_bits(64'(pre), npre);
        send_bits(64'h A5, 8);
        chk($sformatf("%s busy_after_hdr", tag), 64'(w_busy[s]), 64'd1);
        send_bits(64'(op), 2);
        send_bits(64'(a), 4 * d);
        send_bits(64'(b), 4 * d);
        din = 1'b0;
        k = p;
        while (w_res[s] !== 1'b1 && k < p + 2 * d + 8) begin
            tick();
            k++;
        end
        chk($sformatf("%s latency", tag), 64'(k + 1), 64'(p + 2 + calc));
        for (int i = 0; i < l; i++) begin
            rsp = {rsp[62:0], w_res[s]};
            if (w_done[s] === 1'b1) ndone += (i == l - 1) ? 1 : 100;
            if (w_busy[s] !== 1'b1) busy_ok = 1'b0;
            tick();
        end
        chk($sformatf("%s done_pulse", tag), 64'(ndone), 64'd1);
        chk($sformatf("%s busy_frame", tag), 64'(busy_ok), 64'd1);
        chk($sformatf("%s idle_after", tag), 64'({w_busy[s], w_res[s], w_done[s]}), 64'd0);
        chk($sformatf("%s rsp_hdr", tag), (rsp >> (l - 8)) & 64'hFF, 64'h96);
        chk($sformatf("%s status", tag), (rsp >> (4 * d)) & 64'hFF, 64'(exp_st));
        chk($sformatf("%s digits", tag), rsp & ((64'd1 << (4 * d)) - 1), 64'(exp_dig));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, s, ai, bi, calc, nd, mx;
        logic [1:0] op;
        logic [7:0] st;
        logic [23:0] dig;

        reset = 1'b1;
        tick(); tick();
        chk("reset outputs", 64'({w_res, w_busy, w_done}), 64'd0);
        reset = 1'b0;
        tick();

        run_frame("add",      0, 4, 2'b00, 24'h1234, 24'h5678, 8'h00, 24'h6912, 4, 16'h0, 0);
        run_frame("add_ovf",  0, 4, 2'b00, 24'h9999, 24'h0001, 8'h01, 24'h0000, 4, 16'h0, 0);
        run_frame("sub_pos",  0, 4, 2'b01, 24'h0500, 24'h0123, 8'h00, 24'h0377, 4, 16'h0, 0);
        run_frame("sub_neg",  0, 4, 2'b01, 24'h0123, 24'h0500, 8'h02, 24'h0377, 8, 16'h0, 0);
        run_frame("cmp_eq",   0, 4, 2'b10, 24'h0042, 24'h0042, 8'h04, 24'h0000, 4, 16'h0, 0);
        run_frame("cmp_lt",   0, 4, 2'b10, 24'h0041, 24'h0042, 8'h02, 24'h0000, 8, 16'h0, 0);
        run_frame("err_nib",  0, 4, 2'b00, 24'h0A12, 24'h0001, 8'h08, 24'h0000, 0, 16'h0, 0);
        run_frame("err_op",   0, 4, 2'b11, 24'h1234, 24'h5678, 8'h08, 24'h0000, 0, 16'h0, 0);
        run_frame("noise",    0, 4, 2'b00, 24'h0001, 24'h0002, 8'h00, 24'h0003, 4, 16'b011011, 6);
        run_frame("d2_ovf",   1, 2, 2'b00, 24'h99,   24'h01,   8'h01, 24'h00,   2, 16'h0, 0);
        run_frame("d6_neg",   2, 6, 2'b01, 24'h000123, 24'h000500, 8'h02, 24'h000377, 12, 16'h0, 0);

        // Reset during RECV
        sel = 0;
        send_bits(64'hA5, 8);
        send_bits(64'h2AB, 10);
        reset = 1'b1;
        tick();
        chk("reset_recv outputs", 64'({w_res[0], w_busy[0], w_done[0]}), 64'd0);
        reset = 1'b0;
        tick();

        // Reset during SEND
        send_bits(64'hA5, 8);
        send_bits(64'h0, 2);
        send_bits(64'h1234, 16);
        send_bits(64'h5678, 16);
        din = 1'b0;
        for (int i = 0; i < 20 && w_res[0] !== 1'b1; i++) tick();
        chk("reset_send reached", 64'(w_res[0]), 64'd1);
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        chk("reset_send outputs", 64'({w_res[0], w_busy[0], w_done[0]}), 64'd0);
        reset = 1'b0;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            if (w_done[0] === 1'b1 || w_busy[0] === 1'b1) nd++;
            tick();
        end
        chk("reset_send no_done", 64'(nd), 64'd0);
        run_frame("after_rst", 0, 4, 2'b00, 24'h0005, 24'h0005, 8'h00, 24'h0010, 4, 16'h0, 0);

        // Golden decimal model across all three widths
        for (int n = 0; n < 300; n++) begin
            s  = $urandom_range(0, 2);
            d  = (s == 0) ? 4 : (s == 1) ? 2 : 6;
            mx = 1;
            for (int i = 0; i < d; i++) mx = mx * 10;
            ai = $urandom_range(0, mx - 1);
            bi = (n % 7 == 0) ? ai : $urandom_range(0, mx - 1);
            op = 2'($urandom_range(0, 2));
            if (op == 2'b00) begin
                st   = ((ai + bi) >= mx) ? 8'h01 : 8'h00;
                dig  = int2bcd((ai + bi) % mx, d);
                calc = d;
            end else begin
                st   = (ai < bi) ? 8'h02 : 8'h00;
                dig  = int2bcd((ai >= bi) ? ai - bi : bi - ai, d);
                calc = (ai >= bi) ? d : 2 * d;
                if (op == 2'b10) begin
                    dig = '0;
                    if (ai == bi) st = 8'h04;
                end
            end
            run_frame($sformatf("rnd%0d", n), s, d, op, int2bcd(ai, d), int2bcd(bi, d),
                      st, dig, calc, 16'h0, 0);
            if (bcd2int(int2bcd(ai, d), d) != ai) chk("model_roundtrip", 64'(bcd2int(int2bcd(ai, d), d)), 64'(ai));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
